// File: rtl/fetch_buffer_unit_pkg.sv
// Shared types and defaults for the fetch buffer unit and its FIFO.
package fetch_buffer_unit_pkg;

    typedef logic [31:0] u32;
    typedef logic [63:0] u64;

    // One fetched instruction as presented to decode.
    typedef struct packed {
        u32   raw_instr;
        u64   pc;
        logic is_bubble;
    } fetch_data_t;

    localparam int unsigned FETCH_DEPTH = 4;

    typedef enum logic [0:0] {
        RUN     = 1'b0,
        DISCARD = 1'b1
    } fetch_state_t;

    // Entry shown to decode when nothing is valid.
    function automatic fetch_data_t fetch_bubble();
        fetch_data_t b;
        b.raw_instr = '0;
        b.pc        = '0;
        b.is_bubble = 1'b1;
        return b;
    endfunction

endpackage

// File: rtl/fetch_buffer_unit_fifo.sv
// Circular DEPTH-entry FIFO of fetch_data_t with flush; head is the oldest entry.
module fetch_buffer_unit_fifo
    import fetch_buffer_unit_pkg::*;
#(
    parameter int unsigned DEPTH = FETCH_DEPTH
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush,
    input  logic                         push,
    input  fetch_data_t                  push_data,
    input  logic                         pop,
    output fetch_data_t                  head,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    fetch_data_t   mem_q [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_pop;

    assign do_pop = pop && (count_q != '0);
    assign head   = mem_q[rptr_q];
    assign count  = count_q;

    // Pointer and count update; flush empties the FIFO and overrides push/pop.
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (flush) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (push) begin
                wptr_d = wptr_q + AW'(1);
            end
            if (do_pop) begin
                rptr_d = rptr_q + AW'(1);
            end
            count_d = count_q + CW'(push) - CW'(do_pop);
        end
    end

    // Pointer/count registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Storage write; entries need no reset since count gates their visibility.
    always_ff @(posedge clk) begin
        if (!reset && !flush && push) begin
            mem_q[wptr_q] <= push_data;
        end
    end

    // The owner only pushes while not full.
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!(push && !flush && (count_q == CW'(DEPTH))));
        end
    end

endmodule

// File: rtl/fetch_buffer_unit.sv
// Fetch stage: owns the PC, issues one outstanding ibus request at a time and
// buffers returned instructions for decode. A redirect flushes the buffer;
// a request already on the bus is held (DISCARD) until its response arrives,
// which is then dropped. ibus requirement: after reset the bus must not
// return data for a request that was in flight when reset was asserted.
module fetch_buffer_unit
    import fetch_buffer_unit_pkg::*;
#(
    parameter int unsigned DEPTH    = FETCH_DEPTH,
    parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000,
    parameter int unsigned PC_STEP  = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    output logic                         ireq_valid,
    output logic [63:0]                  ireq_addr,
    input  logic                         iresp_valid,
    input  logic [31:0]                  iresp_data,
    input  logic                         redirect_valid,
    input  logic [63:0]                  redirect_pc,
    output logic                         out_valid,
    input  logic                         out_ready,
    output fetch_data_t                  dataF,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

    localparam int unsigned CW = $clog2(DEPTH + 1);

    localparam logic [0:0] ST_RUN     = 1'(RUN);
    localparam logic [0:0] ST_DISCARD = 1'(DISCARD);

    logic [0:0]    state_q, state_d;
    u64            pc_q, pc_d;
    u64            stale_q, stale_d;
    logic          push;
    fetch_data_t   push_data;
    fetch_data_t   head;
    logic [CW-1:0] count;

    // Request generation, PC sequencing and redirect handling.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        stale_d    = stale_q;
        push       = 1'b0;
        ireq_valid = 1'b0;
        ireq_addr  = pc_q;
        case (state_q)
            ST_RUN: begin
                ireq_valid = !reset && (count < CW'(DEPTH));
                if (redirect_valid) begin
                    pc_d = redirect_pc;
                    if (ireq_valid && !iresp_valid) begin
                        stale_d = pc_q;
                        state_d = ST_DISCARD;
                    end
                end else if (ireq_valid && iresp_valid) begin
                    push = 1'b1;
                    pc_d = pc_q + 64'(PC_STEP);
                end
            end
            ST_DISCARD: begin
                ireq_valid = !reset;
                ireq_addr  = stale_q;
                if (redirect_valid) begin
                    pc_d = redirect_pc;
                end
                if (iresp_valid) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // FSM, PC and stale-address registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_RUN;
            pc_q    <= RESET_PC;
            stale_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            stale_q <= stale_d;
        end
    end

    assign push_data.raw_instr = iresp_data;
    assign push_data.pc        = pc_q;
    assign push_data.is_bubble = 1'b0;

    fetch_buffer_unit_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (redirect_valid),
        .push      (push),
        .push_data (push_data),
        .pop       (out_valid && out_ready),
        .head      (head),
        .count     (count)
    );

    assign occupancy = count;
    assign out_valid = (count != '0);
    assign dataF     = out_valid ? head : fetch_bubble();

endmodule

// File: tb/tb_fetch_buffer_unit.sv
// Directed bench for fetch_buffer_unit: streaming, backpressure, redirects,
// DISCARD behaviour and reset out of DISCARD.
module tb_fetch_buffer_unit;
    import fetch_buffer_unit_pkg::*;

    localparam logic [63:0] BASE = 64'h0000_0000_8000_0000;
    localparam logic [31:0] KEY  = 32'h1357_9BDF;

    logic        clk = 1'b0;
    logic        reset;
    logic        ireq_valid;
    logic [63:0] ireq_addr;
    logic        iresp_valid;
    logic [31:0] iresp_data;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    fetch_data_t dataF;
    logic [2:0]  occupancy;

    logic        zero_wait;
    logic        lat_valid;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    // Bus model: zero-wait answers every request; otherwise lat_valid is manual.
    assign iresp_valid = zero_wait ? ireq_valid : lat_valid;
    assign iresp_data  = ireq_addr[31:0] ^ KEY;

    fetch_buffer_unit dut (
        .clk            (clk),
        .reset          (reset),
        .ireq_valid     (ireq_valid),
        .ireq_addr      (ireq_addr),
        .iresp_valid    (iresp_valid),
        .iresp_data     (iresp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .dataF          (dataF),
        .occupancy      (occupancy)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_bubble(input string tag);
        check_val({tag, ".out_valid"}, 64'(out_valid), 64'd0);
        check_val({tag, ".raw"}, 64'(dataF.raw_instr), 64'd0);
        check_val({tag, ".pc"}, dataF.pc, 64'd0);
        check_val({tag, ".bubble"}, 64'(dataF.is_bubble), 64'd1);
    endtask

    task automatic check_head(input string tag, input logic [63:0] pc);
        check_val({tag, ".out_valid"}, 64'(out_valid), 64'd1);
        check_val({tag, ".pc"}, dataF.pc, pc);
        check_val({tag, ".raw"}, 64'(dataF.raw_instr), 64'(pc[31:0] ^ KEY));
        check_val({tag, ".bubble"}, 64'(dataF.is_bubble), 64'd0);
    endtask

    // Advance to the next negedge (inputs are driven there, checks #1 later).
    task automatic next_cyc();
        @(negedge clk);
    endtask

    task automatic do_reset();
        next_cyc(); reset = 1'b1;
        next_cyc(); reset = 1'b1;
    endtask

    initial begin
        reset = 1'b1; zero_wait = 1'b0; lat_valid = 1'b0;
        redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b0;

        // Reset state
        do_reset(); #1;
        check_val("rst.ireq_valid", 64'(ireq_valid), 64'd0);
        check_val("rst.occ", 64'(occupancy), 64'd0);
        check_bubble("rst");

        // Streaming with zero-wait bus and decode always ready
        zero_wait = 1'b1; out_ready = 1'b1;
        next_cyc(); reset = 1'b0; #1;
        check_val("s.ireq_valid0", 64'(ireq_valid), 64'd1);
        check_val("s.addr0", ireq_addr, BASE);
        check_val("s.out_valid0", 64'(out_valid), 64'd0);
        for (int i = 0; i < 4; i++) begin
            next_cyc(); #1;
            check_head("s.head", BASE + 64'(4 * i));
            check_val("s.addr", ireq_addr, BASE + 64'(4 * (i + 1)));
            check_val("s.occ", 64'(occupancy), 64'd1);
        end

        // Backpressure: fill to DEPTH, then drain in order
        out_ready = 1'b0;
        do_reset();
        next_cyc(); reset = 1'b0;
        for (int i = 0; i < 4; i++) next_cyc();
        #1;
        check_val("bp.occ", 64'(occupancy), 64'd4);
        check_val("bp.ireq_valid", 64'(ireq_valid), 64'd0);
        check_head("bp.head", BASE);
        next_cyc(); #1;
        check_val("bp.occ_hold", 64'(occupancy), 64'd4);
        out_ready = 1'b1;
        check_head("bp.d0", BASE);
        next_cyc(); #1;
        check_head("bp.d1", BASE + 64'h4);
        check_val("bp.resume_valid", 64'(ireq_valid), 64'd1);
        check_val("bp.resume_addr", ireq_addr, BASE + 64'h10);
        next_cyc(); #1; check_head("bp.d2", BASE + 64'h8);
        next_cyc(); #1; check_head("bp.d3", BASE + 64'hC);
        next_cyc(); #1; check_head("bp.d4", BASE + 64'h10);

        // Redirect while a slow request is outstanding
        zero_wait = 1'b0; lat_valid = 1'b0;
        do_reset();
        next_cyc(); reset = 1'b0; #1;
        check_val("dis.addr_w1", ireq_addr, BASE);
        next_cyc(); redirect_valid = 1'b1; redirect_pc = BASE + 64'h1000; #1;
        check_val("dis.addr_w2", ireq_addr, BASE);
        next_cyc(); redirect_valid = 1'b0; #1;
        check_val("dis.hold_valid", 64'(ireq_valid), 64'd1);
        check_val("dis.hold_addr", ireq_addr, BASE);
        next_cyc(); lat_valid = 1'b1; #1;
        check_val("dis.resp_addr", ireq_addr, BASE);
        check_val("dis.out_valid", 64'(out_valid), 64'd0);
        next_cyc(); #1;
        check_val("dis.new_addr", ireq_addr, BASE + 64'h1000);
        check_val("dis.occ", 64'(occupancy), 64'd0);
        check_val("dis.no_stale", 64'(out_valid), 64'd0);
        next_cyc(); lat_valid = 1'b0; #1;
        check_head("dis.first", BASE + 64'h1000);

        // Redirect coincident with a response, FIFO holding 2 entries
        out_ready = 1'b0; zero_wait = 1'b1;
        do_reset();
        next_cyc(); reset = 1'b0;
        next_cyc();
        next_cyc(); #1;
        check_val("rr.occ2", 64'(occupancy), 64'd2);
        check_val("rr.addr", ireq_addr, BASE + 64'h8);
        redirect_valid = 1'b1; redirect_pc = BASE + 64'h2000; out_ready = 1'b1;
        next_cyc(); redirect_valid = 1'b0; zero_wait = 1'b0; lat_valid = 1'b0; #1;
        check_val("rr.occ0", 64'(occupancy), 64'd0);
        check_val("rr.out_valid", 64'(out_valid), 64'd0);
        check_val("rr.ireq_valid", 64'(ireq_valid), 64'd1);
        check_val("rr.new_addr", ireq_addr, BASE + 64'h2000);

        // Two redirects during DISCARD
        next_cyc(); redirect_valid = 1'b1; redirect_pc = 64'h100;
        next_cyc(); redirect_valid = 1'b1; redirect_pc = 64'h200; #1;
        check_val("d2.stale1", ireq_addr, BASE + 64'h2000);
        next_cyc(); redirect_valid = 1'b0; lat_valid = 1'b1; #1;
        check_val("d2.stale2", ireq_addr, BASE + 64'h2000);
        next_cyc(); lat_valid = 1'b0; #1;
        check_val("d2.new_addr", ireq_addr, 64'h200);
        check_val("d2.occ", 64'(occupancy), 64'd0);
        check_bubble("d2.empty");

        // Reset while in DISCARD
        next_cyc(); redirect_valid = 1'b1; redirect_pc = 64'h300;
        next_cyc(); redirect_valid = 1'b0; reset = 1'b1; #1;
        check_val("rd.ireq_in_rst", 64'(ireq_valid), 64'd0);
        next_cyc(); reset = 1'b0; #1;
        check_val("rd.addr", ireq_addr, BASE);
        check_val("rd.ireq_valid", 64'(ireq_valid), 64'd1);
        check_val("rd.occ", 64'(occupancy), 64'd0);
        check_bubble("rd.empty");
        lat_valid = 1'b1;
        next_cyc(); lat_valid = 1'b0; #1;
        check_head("rd.first", BASE);
        check_val("rd.next_addr", ireq_addr, BASE + 64'h4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
